exe_alu_stage: RTL



---
 rtl/exe_alu_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/exe_alu_stage.sv
// Integer execute stage: operand select, ALU, branch/jalr resolution, and a
// main+skid output buffer with a one-cycle mispredict redirect pulse.
package alufnt;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SL, ALU_SR, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_XORO, ALU_ORO, ALU_ANDO
    } alufn_t;
endpackage

package opr1t;
    typedef enum logic [1:0] {OPR1_RS1, OPR1_PC, OPR1_ZERO} opr1_t;
endpackage

package opr2t;
    typedef enum logic [0:0] {OPR2_RS2, OPR2_IMM} opr2_t;
endpackage

package brfnt;
    typedef enum logic [2:0] {
        BR_NONE, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } brfn_t;
endpackage

module exe_alu_stage #(
    parameter int TAG_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  alufnt::alufn_t      in_alufn,
    input  opr1t::opr1_t        in_opr1,
    input  opr2t::opr2_t        in_opr2,
    input  brfnt::brfn_t        in_brfn,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_rs1_data,
    input  logic [31:0]         in_rs2_data,
    input  logic [31:0]         in_imm,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                in_pred_taken,
    input  logic [31:0]         in_pred_target,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_br_taken,
    output logic [31:0]         out_br_target,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc
);
    import alufnt::*;
    import opr1t::*;
    import opr2t::*;
    import brfnt::*;

    function automatic logic [31:0] alu_fn(alufn_t fn, logic signed [31:0] a,
                                           logic signed [31:0] b);
        logic [31:0] r;
        r = '0;
        case (fn)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SL:   r = a << b[4:0];
            ALU_SR:   r = $unsigned(a) >> b[4:0];
            ALU_SRA:  r = a >>> b[4:0];
            ALU_SLT:  r = {31'b0, a < b};
            ALU_SLTU: r = {31'b0, $unsigned(a) < $unsigned(b)};
            ALU_XORO: r = a ^ b;
            ALU_ORO:  r = a | b;
            ALU_ANDO: r = a & b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic logic br_cond(brfn_t fn, logic signed [31:0] a,
                                     logic signed [31:0] b);
        logic t;
        t = 1'b0;
        case (fn)
            BR_JALR: t = 1'b1;
            BR_BEQ:  t = (a == b);
            BR_BNE:  t = (a != b);
            BR_BLT:  t = (a < b);
            BR_BGE:  t = (a >= b);
            BR_BLTU: t = ($unsigned(a) < $unsigned(b));
            BR_BGEU: t = ($unsigned(a) >= $unsigned(b));
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic signed [31:0]  rs1_p0, rs2_p0, op1_p0, op2_p0;
    logic [31:0]         alu_p0, pc4_p0, jalr_tgt_p0;
    logic [31:0]         result_p0, target_p0, rpc_p0;
    logic                taken_p0, mispredict_p0;
    logic                accept, consume;

    logic                main_vld_p1, skid_vld_p1, redir_vld_p1;
    logic [31:0]         main_result_p1, main_target_p1, skid_result_p1, skid_target_p1;
    logic [TAG_W-1:0]    main_tag_p1, skid_tag_p1;
    logic                main_taken_p1, skid_taken_p1;
    logic [31:0]         redir_pc_p1;

    // Stage p0: operand select, ALU and branch resolution
    always_comb begin
        rs1_p0 = $signed(in_rs1_data);
        rs2_p0 = $signed(in_rs2_data);
        op1_p0 = rs1_p0;
        case (in_opr1)
            OPR1_PC:   op1_p0 = $signed(in_pc);
            OPR1_ZERO: op1_p0 = '0;
            default:   op1_p0 = rs1_p0;
        endcase
        op2_p0      = (in_opr2 == OPR2_IMM) ? $signed(in_imm) : rs2_p0;
        alu_p0      = alu_fn(in_alufn, op1_p0, op2_p0);
        pc4_p0      = in_pc + 32'd4;
        jalr_tgt_p0 = (in_rs1_data + in_imm) & ~32'h1;
        taken_p0    = br_cond(in_brfn, rs1_p0, rs2_p0);
        result_p0   = alu_p0;
        target_p0   = alu_p0;
        case (in_brfn)
            BR_NONE: target_p0 = pc4_p0;
            BR_JALR: begin
                result_p0 = pc4_p0;
                target_p0 = jalr_tgt_p0;
            end
            default: target_p0 = alu_p0;
        endcase
        mispredict_p0 = (in_brfn != BR_NONE) &&
                        ((taken_p0 != in_pred_taken) ||
                         (taken_p0 && (target_p0 != in_pred_target)));
        rpc_p0 = taken_p0 ? target_p0 : pc4_p0;
    end

    assign accept  = in_valid & in_ready & ~flush;
    assign consume = main_vld_p1 & out_ready;

    // Stage p1: main/skid output buffer and redirect register
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_p1    <= 1'b0;
            skid_vld_p1    <= 1'b0;
            redir_vld_p1   <= 1'b0;
            main_result_p1 <= '0;
            main_target_p1 <= '0;
            main_tag_p1    <= '0;
            main_taken_p1  <= 1'b0;
            skid_result_p1 <= '0;
            skid_target_p1 <= '0;
            skid_tag_p1    <= '0;
            skid_taken_p1  <= 1'b0;
            redir_pc_p1    <= '0;
        end else if (flush) begin
            main_vld_p1  <= 1'b0;
            skid_vld_p1  <= 1'b0;
            redir_vld_p1 <= 1'b0;
        end else begin
            if (consume && skid_vld_p1) begin
                main_vld_p1    <= 1'b1;
                main_result_p1 <= skid_result_p1;
                main_target_p1 <= skid_target_p1;
                main_tag_p1    <= skid_tag_p1;
                main_taken_p1  <= skid_taken_p1;
                skid_vld_p1    <= 1'b0;
            end else if (accept && (consume || !main_vld_p1)) begin
                main_vld_p1    <= 1'b1;
                main_result_p1 <= result_p0;
                main_target_p1 <= target_p0;
                main_tag_p1    <= in_tag;
                main_taken_p1  <= taken_p0;
            end else if (consume) begin
                main_vld_p1 <= 1'b0;
            end
            // Skid only fills when main is held; in_ready blocks a third op.
            if (accept && main_vld_p1 && !consume) begin
                skid_vld_p1    <= 1'b1;
                skid_result_p1 <= result_p0;
                skid_target_p1 <= target_p0;
                skid_tag_p1    <= in_tag;
                skid_taken_p1  <= taken_p0;
            end
            redir_vld_p1 <= accept && mispredict_p0;
            if (accept && mispredict_p0) begin
                redir_pc_p1 <= rpc_p0;
            end
        end
    end

    assign in_ready       = ~skid_vld_p1;
    assign out_valid      = main_vld_p1;
    assign out_result     = main_result_p1;
    assign out_tag        = main_tag_p1;
    assign out_br_taken   = main_taken_p1;
    assign out_br_target  = main_target_p1;
    assign redirect_valid = redir_vld_p1;
    assign redirect_pc    = redir_pc_p1;

endmodule
